ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
//  Runs while EX holds the pipeline via stallreq; ctrl turns stallreq into
//  the stall[5:0] vector that id_ex and the other stage registers consume.
//  Returns quotient (LO) and remainder (HI) as one 64-bit result to EX.
// PARAMETERS
//  WIDTH  32  operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk           in   1        clock; everything updates on posedge
//  rst           in   1        synchronous, active-high reset
//  signed_div_i  in   1        1 = DIV (signed), 0 = DIVU
//  opdata1_i     in   WIDTH    dividend
//  opdata2_i     in   WIDTH    divisor
//  start_i       in   1        request; held high by EX until ready_o is seen
//  annul_i       in   1        abort in-flight op (flush or exception)
//  result_o      out  2*WIDTH  {HI=remainder, LO=quotient}; registered
//  ready_o       out  1        result valid; registered
// BEHAVIOUR
//  - Reset: state=DivFree, cnt=0, ready_o=0, result_o=0. Reset wins over
//    everything, including an op in progress.
//  - States: DivFree, DivByZero, DivOn, DivEnd (2-bit encoding).
//  - DivFree: start_i=1 and annul_i=0 -> latch operands; divisor==0 ->
//    DivByZero, else -> DivOn with cnt=0. Operands take absolute value when
//    signed_div_i=1 and MSB=1. Work reg: dividend = {WIDTH'b0, |op1|, 1'b0}
//    (2*WIDTH+1 bits). Otherwise stay; ready_o=0, result_o=0.
//  - DivByZero: next edge -> DivEnd; result_o=0, ready_o=1.
//  - DivOn, annul_i=0, cnt<WIDTH: minuend = dividend[2W:W] - {1'b0,|op2|}.
//      Borrow (minuend MSB=1): dividend <<= 1.
//      Else: dividend = {minuend[W-1:0], dividend[W-1:0], 1'b1}.
//      cnt <= cnt+1.
//  - DivOn, cnt==WIDTH: fix signs (signed only): quotient negated when
//    op1 MSB ^ op2 MSB; remainder negated when op1 MSB. Then
//    result_o = {rem=dividend[2W:W+1], quo=dividend[W-1:0]},
//    ready_o=1, -> DivEnd, cnt=0.
//  - DivOn, annul_i=1 (any cnt): -> DivFree, cnt=0, ready_o=0. No result.
//  - DivEnd: result_o and ready_o held while start_i=1. start_i=0 ->
//    DivFree with ready_o=0 and result_o=0 on that edge.
//  - annul_i is ignored in DivByZero and DivEnd. start_i is ignored
//    outside DivFree; operands are sampled only on the accepting edge.
//  - Latency: accepting edge E0 -> ready_o=1 after edge E0+WIDTH+1
//    (33 cycles of DivOn at WIDTH=32). Divide by zero: ready after E0+1.
//  - Overflow: signed 0x80000000 / -1 -> LO=0x80000000, HI=0. No trap.
//  - Back-to-back: after DivEnd->DivFree, a new start is accepted on the
//    following edge. There is no bypass from DivEnd.
//  - Counter width: $clog2(WIDTH)+1. Subtractor width: WIDTH+1.
// STRUCTURE
//  - Shared defines file: DivFree/DivByZero/DivOn/DivEnd,
//    DivResultReady/DivResultNotReady, DivStart/DivStop, DoubleRegBus.
//    Also EXE_DIV_OP/EXE_DIVU_OP; EX decodes these to drive start_i and
//    signed_div_i.
//  - Single module. Negate/abs is inline; no sub-module.
//  - EX drives stallreq = start_i & ~ready_o.
// TESTING
//  1 DIVU 100/7 -> after 33 DivOn cycles: LO=14, HI=2, ready_o=1;
//    start_i held 3 cycles -> outputs stable; start_i=0 -> next cycle
//    ready_o=0, result_o=0.
//  2 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIV 7/-2 -> LO=0xFFFFFFFD, HI=1.
//  3 DIVU 5/0 -> ready_o=1 one edge after accept, result_o=0.
//  4 Annul at cnt=10 -> DivFree, ready_o never rises.
//    New DIVU 9/3 on the next cycle -> LO=3, HI=0.
//  5 rst=1 at cnt=20 -> ready_o=0, result_o=0, state DivFree.
//    Op restarted after reset completes correctly.
//  6 DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//    DIVU 0xFFFFFFFF/1 -> LO=0xFFFFFFFF, HI=0.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared constants for the EX-stage divider and its decode.
//   - Divider FSM state codes (2-bit, legacy encoding).
//   - Result-ready and start/stop level names used between EX and the divider.
//   - Width of the combined {HI, LO} result bus.
//   - ALU op codes that EX decodes into start_i / signed_div_i.
package ex_div_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_FREE    = 2'b00;
  localparam div_state_t DIV_BY_ZERO = 2'b01;
  localparam div_state_t DIV_ON      = 2'b10;
  localparam div_state_t DIV_END     = 2'b11;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int DOUBLE_REG_BUS_W = 64;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider used by the EX stage for
// DIV / DIVU. EX stalls the pipeline (stallreq = start_i & ~ready_o) while
// the divider iterates one quotient bit per cycle.
// Ports:
//   clk           clock, all state updates on posedge
//   rst           synchronous active-high reset, overrides everything
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held by EX until ready_o is observed
//   annul_i       abort an operation in progress (flush / exception)
//   result_o      {HI = remainder, LO = quotient}, registered
//   ready_o       result valid, registered
import ex_div_pkg::*;

module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t          state_r;
  logic [CW-1:0]       cnt_r;
  logic [2*WIDTH:0]    dividend_r;   // {partial remainder, dividend/quotient, spare}
  logic [WIDTH-1:0]    divisor_r;    // magnitude of the divisor
  logic                quo_neg_r;    // quotient must be negated at the end
  logic                rem_neg_r;    // remainder must be negated at the end

  logic [WIDTH-1:0]    op1_abs_s;
  logic [WIDTH-1:0]    op2_abs_s;
  logic [WIDTH:0]      minuend_s;
  logic [2*WIDTH:0]    dividend_next_s;
  logic [WIDTH-1:0]    quo_fix_s;
  logic [WIDTH-1:0]    rem_fix_s;

  // Operand magnitudes, one restoring-division step, and final sign fix-up.
  always_comb begin
    op1_abs_s       = opdata1_i;
    op2_abs_s       = opdata2_i;
    minuend_s       = dividend_r[2*WIDTH:WIDTH] - {1'b0, divisor_r};
    dividend_next_s = dividend_r;
    quo_fix_s       = dividend_r[WIDTH-1:0];
    rem_fix_s       = dividend_r[2*WIDTH:WIDTH+1];

    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      op1_abs_s = ~opdata1_i + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      op1_abs_s = opdata1_i;
    end

    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      op2_abs_s = ~opdata2_i + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      op2_abs_s = opdata2_i;
    end

    // A borrow out of the subtract means the divisor did not fit: shift only.
    if (minuend_s[WIDTH]) begin
      dividend_next_s = {dividend_r[2*WIDTH-1:0], 1'b0};
    end else begin
      dividend_next_s = {minuend_s[WIDTH-1:0], dividend_r[WIDTH-1:0], 1'b1};
    end

    if (quo_neg_r) begin
      quo_fix_s = ~dividend_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      quo_fix_s = dividend_r[WIDTH-1:0];
    end

    if (rem_neg_r) begin
      rem_fix_s = ~dividend_r[2*WIDTH:WIDTH+1] + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rem_fix_s = dividend_r[2*WIDTH:WIDTH+1];
    end
  end

  // Divider FSM, iteration datapath and registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DIV_FREE;
      cnt_r      <= {CW{1'b0}};
      dividend_r <= {(2*WIDTH+1){1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      quo_neg_r  <= 1'b0;
      rem_neg_r  <= 1'b0;
      result_o   <= {(2*WIDTH){1'b0}};
      ready_o    <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_r)
        DIV_FREE: begin
          result_o <= {(2*WIDTH){1'b0}};
          ready_o  <= DIV_RESULT_NOT_READY;
          if ((start_i == DIV_START) && !annul_i) begin
            cnt_r      <= {CW{1'b0}};
            divisor_r  <= op2_abs_s;
            dividend_r <= {{WIDTH{1'b0}}, op1_abs_s, 1'b0};
            quo_neg_r  <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rem_neg_r  <= signed_div_i & opdata1_i[WIDTH-1];
            if (opdata2_i == {WIDTH{1'b0}}) begin
              state_r <= DIV_BY_ZERO;
            end else begin
              state_r <= DIV_ON;
            end
          end else begin
            state_r <= DIV_FREE;
          end
        end
        DIV_BY_ZERO: begin
          state_r  <= DIV_END;
          result_o <= {(2*WIDTH){1'b0}};
          ready_o  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            state_r <= DIV_FREE;
            cnt_r   <= {CW{1'b0}};
            ready_o <= DIV_RESULT_NOT_READY;
          end else if (cnt_r != CNT_LAST) begin
            dividend_r <= dividend_next_s;
            cnt_r      <= cnt_r + CNT_ONE;
          end else begin
            result_o <= {rem_fix_s, quo_fix_s};
            ready_o  <= DIV_RESULT_READY;
            state_r  <= DIV_END;
            cnt_r    <= {CW{1'b0}};
          end
        end
        DIV_END: begin
          // Result is held until EX drops the request; no bypass to a new op.
          if (start_i == DIV_STOP) begin
            state_r  <= DIV_FREE;
            result_o <= {(2*WIDTH){1'b0}};
            ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            state_r <= DIV_END;
          end
        end
        default: begin
          state_r  <= DIV_FREE;
          cnt_r    <= {CW{1'b0}};
          result_o <= {(2*WIDTH){1'b0}};
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed, table-driven bench for ex_div (WIDTH = 32).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks;
  int failures;

  ex_div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;   // edges from request to ready, accepting edge counted as 1
    int          hold;  // extra cycles start_i stays high after ready
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for ready, check result, hold, release.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input int lat, input int hold, input string name);
    int n;
    logic [63:0] res;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready_o && n < 100);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_lo"}, {32'h0, result_o[31:0]}, {32'h0, lo});
    check({name, "_hi"}, {32'h0, result_o[63:32]}, {32'h0, hi});
    res = result_o;
    // Operands change under a held request: must have no effect.
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'h0000_0003;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, "_hold_ready"}, {63'h0, ready_o}, 64'h1);
      check({name, "_hold_result"}, result_o, res);
    end
    start_i = 1'b0;
    tick();
    check({name, "_drop_ready"}, {63'h0, ready_o}, 64'h0);
    check({name, "_drop_result"}, result_o, 64'h0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,         34, 3};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        34, 1};
    vecs[3] = '{1'b0, 32'd5,          32'd0,        32'd0,         32'd0,         2,  2};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        34, 0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,         34, 0};
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 34, 0};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'd3,        32'h2AAA_AAAA, 32'd2,         34, 0};
    vecs[8] = '{1'b0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1,         34, 0};
    vecs[9] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'd0,         32'd0,         2,  0};

    tick();
    tick();
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].sgn, vecs[v].a, vecs[v].b, vecs[v].lo, vecs[v].hi,
             vecs[v].lat, vecs[v].hold, $sformatf("vec%0d", v));
    end

    // Annul at cnt=10, then a new DIVU 9/3 on the next cycle.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul_ready", {63'h0, ready_o}, 64'h0);
    check("annul_result", result_o, 64'h0);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 0, "after_annul");

    // Synchronous reset at cnt=20, then restart.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_i = 1'b0;
    check("midop_rst_ready", {63'h0, ready_o}, 64'h0);
    check("midop_rst_result", result_o, 64'h0);
    run_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 0, "after_rst");

    // Annul is ignored in DivByZero.
    opdata1_i = 32'd7;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul_in_byzero_ready", {63'h0, ready_o}, 64'h1);

    // Reset wins while a result is being held in DivEnd.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("divend_rst_ready", {63'h0, ready_o}, 64'h0);
    check("divend_rst_result", result_o, 64'h0);
    start_i = 1'b0;
    tick();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'd0, 34, 0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
